// File: rtl/adc_sar_seq_pkg.sv
// Shared types and default sizing for the SAR ADC scan sequencer and its conversion core.
package adc_sar_seq_pkg;

    localparam int DEF_N            = 12;
    localparam int DEF_NCH          = 4;
    localparam int DEF_AVG_LOG2_MAX = 4;
    localparam int DEF_SAMPLE_CYC   = 4;
    localparam int DEF_RDY_TIMEOUT  = 15;

    localparam int CH_W  = (DEF_NCH > 1) ? $clog2(DEF_NCH) : 1;
    localparam int AVG_W = $clog2(DEF_AVG_LOG2_MAX + 1);
    localparam int ACC_W = DEF_N + DEF_AVG_LOG2_MAX;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SAMPLE,
        CONVERT,
        ACCUM,
        RESULT
    } adc_sar_seq_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SAMPLE,
        PH_CONV
    } adc_sar_core_phase_t;

    // Index widths never collapse to zero bits, even for a single channel.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/adc_sar_seq_core.sv
// Single-conversion SAR engine: sample window, MSB-first binary search, per-bit ms_rdy timeout.
module adc_sar_seq_core
    import adc_sar_seq_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int SAMPLE_CYC  = DEF_SAMPLE_CYC,
    parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         ms_rdy,
    input  logic         ms_cmp,
    output logic         sample_done,
    output logic         done,
    output logic         timeout,
    output logic [N-1:0] code,
    output logic         ms_sample,
    output logic [N-1:0] ms_dac,
    output logic         ms_clk
);

    localparam int SW = clog2_min1(SAMPLE_CYC);
    localparam int WW = clog2_min1(RDY_TIMEOUT);
    localparam int BW = clog2_min1(N);

    adc_sar_core_phase_t phase;
    logic [SW-1:0] scnt;
    logic [WW-1:0] wcnt;
    logic [BW-1:0] bit_idx;
    logic [N-1:0]  res;
    logic          rdy_ok;
    logic          bit_end;
    logic          gate_en;

    // ms_rdy in the first cycle of a bit is ignored so every bit takes at least two cycles.
    assign rdy_ok      = ms_rdy && (wcnt != '0);
    assign bit_end     = (phase == PH_CONV) && (rdy_ok || (wcnt == WW'(RDY_TIMEOUT - 1)));
    assign timeout     = bit_end && !rdy_ok;
    assign done        = bit_end && (bit_idx == '0);
    assign sample_done = (phase == PH_SAMPLE) && (scnt == SW'(SAMPLE_CYC - 1));
    assign code        = res;
    assign ms_sample   = (phase == PH_SAMPLE);
    assign ms_dac      = (phase == PH_CONV) ? (res | (N'(1) << bit_idx)) : '0;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            phase   <= PH_IDLE;
            scnt    <= '0;
            wcnt    <= '0;
            bit_idx <= '0;
            res     <= '0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase <= PH_SAMPLE;
                        scnt  <= '0;
                        res   <= '0;
                    end
                end
                PH_SAMPLE: begin
                    if (sample_done) begin
                        phase   <= PH_CONV;
                        bit_idx <= BW'(N - 1);
                        wcnt    <= '0;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                PH_CONV: begin
                    if (bit_end) begin
                        res[bit_idx] <= rdy_ok & ms_cmp;
                        wcnt         <= '0;
                        if (bit_idx == '0) phase <= PH_IDLE;
                        else bit_idx <= bit_idx - 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

    // Enable captured on the falling edge keeps the gated comparator clock glitch-free.
    always_ff @(negedge clk) begin
        gate_en <= (phase == PH_CONV) && !rst;
    end

    assign ms_clk = clk & gate_en;

endmodule

// File: rtl/adc_sar_seq.sv
// SAR ADC scan sequencer with per-channel 2**k averaging; `ADC_SAR_SEQ_WINDOW_EN adds a window comparator.
module adc_sar_seq
    import adc_sar_seq_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int NCH          = DEF_NCH,
    parameter int AVG_LOG2_MAX = DEF_AVG_LOG2_MAX,
    parameter int SAMPLE_CYC   = DEF_SAMPLE_CYC,
    parameter int RDY_TIMEOUT  = DEF_RDY_TIMEOUT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic                                   soc,
    input  logic [NCH-1:0]                         ch_mask,
    input  logic [clog2_min1(AVG_LOG2_MAX+1)-1:0]  avg_log2,
    input  logic                                   continuous,
    output logic                                   eoc,
    output logic                                   eoc_it,
    output logic                                   eoa,
    output logic [N-1:0]                           dout,
    output logic [clog2_min1(NCH)-1:0]             dout_ch,
    output logic                                   err_timeout,
`ifdef ADC_SAR_SEQ_WINDOW_EN
    input  logic [N-1:0]                           win_lo,
    input  logic [N-1:0]                           win_hi,
    output logic                                   win_it,
`endif
    output logic                                   ms_clk,
    output logic                                   ms_sample,
    output logic [clog2_min1(NCH)-1:0]             ms_chsel,
    output logic [N-1:0]                           ms_dac,
    input  logic                                   ms_rdy,
    input  logic                                   ms_cmp
);

    localparam int CHW  = clog2_min1(NCH);
    localparam int AW   = clog2_min1(AVG_LOG2_MAX + 1);
    localparam int ACCW = N + AVG_LOG2_MAX;
    localparam int CNTW = AVG_LOG2_MAX + 1;

    adc_sar_seq_state_t state, next_state;
    logic [NCH-1:0]  rem_q;
    logic [AW-1:0]   avg_q;
    logic [CHW-1:0]  chan_q;
    logic [CNTW-1:0] conv_cnt;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_sum;
    logic [N-1:0]    code;
    logic            core_start;
    logic            sample_done;
    logic            conv_done;
    logic            bit_timeout;
    logic            more_ch;
    logic            last_conv;

    function automatic logic [CHW-1:0] lowest(input logic [NCH-1:0] m);
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest = CHW'(i);
        end
    endfunction

    assign more_ch    = |rem_q;
    assign acc_sum    = acc_q + ACCW'(code);
    assign last_conv  = (conv_cnt + 1'b1) == (CNTW'(1) << avg_q);
    assign core_start = enable && ((state == SELECT) || (state == ACCUM && !last_conv));

    adc_sar_seq_core #(
        .N           (N),
        .SAMPLE_CYC  (SAMPLE_CYC),
        .RDY_TIMEOUT (RDY_TIMEOUT)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start       (core_start),
        .abort       (!enable),
        .ms_rdy      (ms_rdy),
        .ms_cmp      (ms_cmp),
        .sample_done (sample_done),
        .done        (conv_done),
        .timeout     (bit_timeout),
        .code        (code),
        .ms_sample   (ms_sample),
        .ms_dac      (ms_dac),
        .ms_clk      (ms_clk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem_q       <= '0;
            avg_q       <= '0;
            chan_q      <= '0;
            conv_cnt    <= '0;
            acc_q       <= '0;
            dout        <= '0;
            dout_ch     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if (bit_timeout) err_timeout <= 1'b1;
            else if (state == IDLE && next_state == SELECT) err_timeout <= 1'b0;

            // A fresh scan (from IDLE or a continuous restart) re-latches the mask and depth.
            if (next_state == SELECT && (state == IDLE || !more_ch)) begin
                rem_q  <= ch_mask;
                chan_q <= lowest(ch_mask);
                avg_q  <= (avg_log2 > AW'(AVG_LOG2_MAX)) ? AW'(AVG_LOG2_MAX) : avg_log2;
            end else if (next_state == SELECT) begin
                chan_q <= lowest(rem_q);
            end

            if (state == SELECT) begin
                rem_q    <= rem_q & ~(NCH'(1) << chan_q);
                conv_cnt <= '0;
                acc_q    <= '0;
            end
            if (state == ACCUM && enable) begin
                acc_q    <= acc_sum;
                conv_cnt <= conv_cnt + 1'b1;
            end
            if (state == ACCUM && next_state == RESULT) begin
                dout    <= N'(acc_sum >> avg_q);
                dout_ch <= chan_q;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (soc && |ch_mask) next_state = SELECT;
                SELECT:  next_state = SAMPLE;
                SAMPLE:  if (sample_done) next_state = CONVERT;
                CONVERT: if (conv_done) next_state = ACCUM;
                ACCUM:   next_state = last_conv ? RESULT : SAMPLE;
                RESULT:  next_state = (more_ch || (continuous && |ch_mask)) ? SELECT : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        eoc      = (state == IDLE);
        eoc_it   = (state == RESULT);
        eoa      = (state == RESULT) && !more_ch;
        ms_chsel = (state == IDLE) ? '0 : chan_q;
    end

`ifdef ADC_SAR_SEQ_WINDOW_EN
    assign win_it = eoc_it && (win_lo <= win_hi) && ((dout < win_lo) || (dout > win_hi));
`endif

endmodule
